// File: rtl/wd279x_cmd_dispatch.sv
// wd279x_cmd_dispatch
// Command dispatcher for the WD279x FDC core: latches command-register writes,
// decodes them into Type I/II/III/IV, pulses the matching unit start, tracks
// completion, and produces INTRQ, BUSY and the CPU-visible status byte.
//
// Optional feature macro: WD279X_FORCE_INT_COND_EN
//   defined   -> force-interrupt conditions [2:0] (index / ready edges) built
//   undefined -> only immediate force interrupt [3] and plain 0xD0 honored
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no command in progress, accepts a new command write
// START  | command latched, start pulse for the selected unit issued
// RUN    | waiting for the unit's busy to rise and fall (or timeout)

module wd279x_cmd_dispatch #(
  parameter int START_TIMEOUT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_wr,
  input  logic [7:0] cmd_wdata,
  input  logic       status_rd,
  output logic [7:0] command,
  output logic       start_I,
  output logic       start_II,
  output logic       start_III,
  output logic       abort,
  input  logic       busy_I,
  input  logic       busy_II,
  input  logic       busy_III,
  input  logic [7:0] status_I,
  input  logic [7:0] status_II,
  input  logic [7:0] status_III,
  input  logic       INDEXn,
  input  logic       READYn,
  output logic       INTRQ,
  output logic       BUSY,
  output logic [7:0] status
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN} state_t;

  localparam logic [1:0] T_I   = 2'd0;
  localparam logic [1:0] T_II  = 2'd1;
  localparam logic [1:0] T_III = 2'd2;

  localparam logic [2:0] TMO = 3'(START_TIMEOUT);

  state_t      state, state_nxt;
  logic [7:0]  command_nxt;
  logic [1:0]  last_type, last_type_nxt;
  logic        start_I_nxt, start_II_nxt, start_III_nxt;
  logic        abort_nxt;
  logic        intrq_nxt;
  logic        force_imm, force_imm_nxt;
  logic        seen_busy, seen_busy_nxt;
  logic [2:0]  tcnt, tcnt_nxt;
  logic        is_iv;
  logic [1:0]  dec_type;
  logic        sel_busy;
  logic        done;
  logic        cond_evt;

`ifdef WD279X_FORCE_INT_COND_EN
  logic [2:0] force_cond, force_cond_nxt;
  logic       index_q, ready_q;

  // Register the drive signals so their edges can be detected.
  always_ff @(posedge clk) begin
    if (reset) begin
      index_q <= 1'b1;
      ready_q <= 1'b1;
    end else begin
      index_q <= INDEXn;
      ready_q <= READYn;
    end
  end

  // Armed index-fall, ready-rise and ready-fall conditions raise INTRQ.
  always_comb begin
    cond_evt = (force_cond[2] &  index_q & ~INDEXn) |
               (force_cond[1] & ~ready_q &  READYn) |
               (force_cond[0] &  ready_q & ~READYn);
  end
`else
  logic unused_drive_pins;
  assign unused_drive_pins = INDEXn ^ READYn;
  assign cond_evt = 1'b0;
`endif

  // Decode the written byte and select the unit belonging to last_type.
  always_comb begin
    is_iv    = (cmd_wdata[7:4] == 4'hD);
    dec_type = T_III;
    if (!cmd_wdata[7])      dec_type = T_I;
    else if (!cmd_wdata[6]) dec_type = T_II;
    case (last_type)
      T_II:    begin sel_busy = busy_II;  status = status_II;  end
      T_III:   begin sel_busy = busy_III; status = status_III; end
      default: begin sel_busy = busy_I;   status = status_I;   end
    endcase
    BUSY = (state != S_IDLE) | sel_busy;
  end

  // Next-state and registered-output logic; a Type IV write overrides everything.
  always_comb begin
    state_nxt      = state;
    command_nxt    = command;
    last_type_nxt  = last_type;
    start_I_nxt    = 1'b0;
    start_II_nxt   = 1'b0;
    start_III_nxt  = 1'b0;
    abort_nxt      = 1'b0;
    intrq_nxt      = INTRQ;
    force_imm_nxt  = force_imm;
    seen_busy_nxt  = seen_busy;
    tcnt_nxt       = tcnt;
    done           = 1'b0;
`ifdef WD279X_FORCE_INT_COND_EN
    force_cond_nxt = force_cond;
`endif

    case (state)
      S_START: begin
        start_I_nxt   = (last_type == T_I);
        start_II_nxt  = (last_type == T_II);
        start_III_nxt = (last_type == T_III);
        seen_busy_nxt = 1'b0;
        tcnt_nxt      = 3'd0;
        state_nxt     = S_RUN;
      end
      S_RUN: begin
        if (sel_busy) seen_busy_nxt = 1'b1;
        if (tcnt != 3'd7) tcnt_nxt = tcnt + 3'd1;
        if ((seen_busy && !sel_busy) || (!seen_busy && (tcnt == TMO))) begin
          done      = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: ;
    endcase

    // A set source beats a status read in the same cycle.
    if (status_rd && !force_imm) intrq_nxt = 1'b0;
    if (done || force_imm || cond_evt) intrq_nxt = 1'b1;

    if (cmd_wr) begin
      if (is_iv) begin
        abort_nxt     = 1'b1;
        state_nxt     = S_IDLE;
        start_I_nxt   = 1'b0;
        start_II_nxt  = 1'b0;
        start_III_nxt = 1'b0;
        if (state == S_IDLE) last_type_nxt = T_I;
        intrq_nxt     = cmd_wdata[3];
        force_imm_nxt = cmd_wdata[3];
`ifdef WD279X_FORCE_INT_COND_EN
        force_cond_nxt = cmd_wdata[2:0];
`endif
      end else if (state == S_IDLE) begin
        command_nxt   = cmd_wdata;
        last_type_nxt = dec_type;
        intrq_nxt     = 1'b0;
        force_imm_nxt = 1'b0;
`ifdef WD279X_FORCE_INT_COND_EN
        force_cond_nxt = 3'b000;
`endif
        state_nxt     = S_START;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      command    <= 8'h00;
      last_type  <= T_I;
      start_I    <= 1'b0;
      start_II   <= 1'b0;
      start_III  <= 1'b0;
      abort      <= 1'b0;
      INTRQ      <= 1'b0;
      force_imm  <= 1'b0;
      seen_busy  <= 1'b0;
      tcnt       <= 3'd0;
`ifdef WD279X_FORCE_INT_COND_EN
      force_cond <= 3'b000;
`endif
    end else begin
      state      <= state_nxt;
      command    <= command_nxt;
      last_type  <= last_type_nxt;
      start_I    <= start_I_nxt;
      start_II   <= start_II_nxt;
      start_III  <= start_III_nxt;
      abort      <= abort_nxt;
      INTRQ      <= intrq_nxt;
      force_imm  <= force_imm_nxt;
      seen_busy  <= seen_busy_nxt;
      tcnt       <= tcnt_nxt;
`ifdef WD279X_FORCE_INT_COND_EN
      force_cond <= force_cond_nxt;
`endif
    end
  end

endmodule

// File: doc/wd279x_cmd_dispatch.md
# wd279x_cmd_dispatch

Command dispatcher for the WD279x FDC core. It latches CPU writes to the command register and decodes each into Type I (seek/step), Type II (sector), Type III (address/track) or Type IV (force interrupt). It pulses a start to the matching command unit and tracks completion. It aggregates INTRQ, BUSY and the status byte seen by the CPU, and implements force-interrupt conditions.

## Interface
Parameters:
- START_TIMEOUT, default 4: cycles to wait for the started unit's busy to rise before declaring completion.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd_wr  in  1  one-cycle CPU write strobe to the command register
- cmd_wdata  in  8  written command byte
- status_rd  in  1  one-cycle CPU read strobe of the status register
- command  out  8  latched command, shared by all units
- start_I / start_II / start_III  out  1 each  one-cycle start pulse to each unit
- abort  out  1  one-cycle abort pulse to all units (drives their interrupt input)
- busy_I / busy_II / busy_III  in  1 each  unit busy levels
- status_I / status_II / status_III  in  8 each  unit status bytes
- INDEXn, READYn  in  1  drive index and ready, active low
- INTRQ  out  1  interrupt request to the CPU
- BUSY  out  1  combined busy
- status  out  8  status byte presented to the CPU

## Operation
- Decode of cmd_wdata:
  - [7]=0 → I
  - [7:6]=10 → II
  - [7:4]∈{C,E,F} → III
  - [7:4]=D → IV
- States: IDLE, START, RUN.
- IDLE:
  - Non-IV write: command<=cmd_wdata, last_type<=decoded type, INTRQ<=0, force flags cleared, go to START.
- START:
  - Assert the matching start_x for exactly one cycle.
  - Clear seen_busy and the timeout counter.
  - Go to RUN.
- RUN:
  - seen_busy sets when the selected busy_x=1.
  - Completion: (seen_busy && busy_x=0) or timeout counter reaches START_TIMEOUT without seen_busy.
  - On completion: go to IDLE, INTRQ<=1.
- Non-IV write while in START or RUN: ignored, with no state change.
- Type IV write, accepted in any state:
  - abort pulses one cycle; state goes to IDLE the next cycle.
  - command is not updated.
  - If the write arrives while IDLE, last_type<=I.
  - INTRQ<=0, then force flags are loaded from cmd_wdata[3:0].
- Force flags, active until the next command write:
  - [3]: INTRQ set immediately and held; status_rd does not clear it.
  - [2]: INTRQ set on each INDEXn 1→0 edge.
  - [1]: INTRQ set on each READYn 0→1 edge.
  - [0]: INTRQ set on each READYn 1→0 edge.
  - 0xD0: no interrupt.
- status_rd clears INTRQ unless force flag [3] is set.
- status = status_x selected by last_type. BUSY = (state≠IDLE) | busy of last_type unit.
- Edge detectors register INDEXn and READYn each cycle. Their reset value is 1.

## Timing
- Reset: state IDLE, command=0x00, last_type=I, all start_x=0, abort=0, INTRQ=0, force flags=0, seen_busy=0.
  - BUSY follows its formula; status shows status_I.
- Write at cycle N: command is valid at N+1, start_x is high at N+2, and BUSY is high from N+1.
- Completion detected at cycle M: INTRQ and state IDLE take effect at M+1.
- Type IV write at cycle N: abort high at N+1, state IDLE at N+1, D8 INTRQ high at N+1.
- Completion and Type IV write in the same cycle: Type IV wins. INTRQ ends at 0 (or 1 if flag [3]) and abort still pulses.
- status_rd in the same cycle as a completion: set wins, so INTRQ=1.
- Reset mid-RUN: immediate return to reset values, no abort pulse.
- Timeout counter is 3 bits wide and saturates.

## Configuration
- WD279X_FORCE_INT_COND_EN defined: force flags [2:0] are implemented as described.
- Undefined: only [3] and 0xD0 are honored; bits [2:0] are ignored and INTRQ is never set by INDEXn or READYn edges. The edge detectors are not built.

## Test plan
- Write 0x03 (restore) while IDLE; model busy_I high for 10 cycles → start_I at N+2, BUSY high N+1 through fall+1, INTRQ=1 after busy_I falls, status=status_I.
- Write 0x88 while busy_II is high, then write 0x1F mid-RUN → second write ignored, command stays 0x88, only start_II pulses.
- Write 0xD8 during RUN → abort one cycle, INTRQ=1 persists across status_rd, cleared by next write 0x00.
- Write 0xD4, then toggle INDEXn low three times → three INTRQ sets, each cleared by status_rd (with the macro); no INTRQ without the macro.
- Write 0xC0 with busy_III never rising → completion after START_TIMEOUT=4 cycles, INTRQ=1.
- Assert reset during RUN of 0x88 → outputs return to reset values next cycle, no abort, status=status_I.
